// File: rtl/addsub_operand_sequencer.sv
// Operand entry sequencer for the 2-bit adder/subtractor: debounced push-button steps A -> B+mode -> execute -> show.
// Capture latency: 2 sync + DEBOUNCE_CYCLES cycles from stable press to load_pulse; result lands one cycle after op_b.
module addsub_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    input  logic       sw_mode,
    input  logic       btn_load,
    output logic [1:0] op_a,
    output logic [1:0] op_b,
    output logic       op_mode,
    input  logic [1:0] add_sum,
    input  logic       add_cout,
    output logic [1:0] result,
    output logic       result_cout,
    output logic       result_valid,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_meta;
    logic          btn_sync;
    logic          btn_db;
    logic [CW-1:0] db_cnt;
    logic          db_expire;
    logic          load_pulse;

    // The level flips on the same edge the counter would reach its limit.
    assign db_expire = (btn_sync != btn_db) && (db_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_db     <= 1'b0;
            db_cnt     <= '0;
            load_pulse <= 1'b0;
        end else begin
            btn_meta   <= btn_load;
            btn_sync   <= btn_meta;
            load_pulse <= db_expire && !btn_db;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_expire) begin
                btn_db <= ~btn_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op_a_nxt;
    logic [1:0] op_b_nxt;
    logic       op_mode_nxt;
    logic [1:0] result_nxt;
    logic       result_cout_nxt;
    logic       result_valid_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_A;
            op_a         <= 2'b00;
            op_b         <= 2'b00;
            op_mode      <= 1'b0;
            result       <= 2'b00;
            result_cout  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            op_a         <= op_a_nxt;
            op_b         <= op_b_nxt;
            op_mode      <= op_mode_nxt;
            result       <= result_nxt;
            result_cout  <= result_cout_nxt;
            result_valid <= result_valid_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        op_a_nxt         = op_a;
        op_b_nxt         = op_b;
        op_mode_nxt      = op_mode;
        result_nxt       = result;
        result_cout_nxt  = result_cout;
        result_valid_nxt = result_valid;
        case (state)
            S_A: begin
                if (load_pulse) begin
                    op_a_nxt  = sw;
                    state_nxt = S_B;
                end
            end
            S_B: begin
                if (load_pulse) begin
                    op_b_nxt    = sw;
                    op_mode_nxt = sw_mode;
                    state_nxt   = S_EXEC;
                end
            end
            // The stage is combinational from op_*, so its outputs are settled by now.
            S_EXEC: begin
                result_nxt       = add_sum;
                result_cout_nxt  = add_cout;
                result_valid_nxt = 1'b1;
                state_nxt        = S_SHOW;
            end
            S_SHOW: begin
                if (load_pulse) begin
                    result_valid_nxt = 1'b0;
                    state_nxt        = S_A;
                end
            end
            default: state_nxt = S_A;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// Directed bench for addsub_operand_sequencer with an ideal 2-bit add/sub stage closing the loop.
module tb_addsub_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw;
    logic       sw_mode;
    logic       btn_load;
    logic [1:0] op_a;
    logic [1:0] op_b;
    logic       op_mode;
    logic [1:0] add_sum;
    logic       add_cout;
    logic [1:0] result;
    logic       result_cout;
    logic       result_valid;
    logic [1:0] phase;

    int checks = 0;
    int passes = 0;

    logic [1:0] b_eff;
    logic [2:0] stage;
    assign b_eff    = op_mode ? ~op_b : op_b;
    assign stage    = {1'b0, op_a} + {1'b0, b_eff} + {2'b00, op_mode};
    assign add_sum  = stage[1:0];
    assign add_cout = stage[2];

    always #5 clk = ~clk;

    addsub_operand_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .sw_mode(sw_mode), .btn_load(btn_load),
        .op_a(op_a), .op_b(op_b), .op_mode(op_mode),
        .add_sum(add_sum), .add_cout(add_cout),
        .result(result), .result_cout(result_cout), .result_valid(result_valid),
        .phase(phase)
    );

    // Press and hold until the FSM has consumed the pulse (19 edges after btn rises).
    task automatic press_hold();
        btn_load = 1'b1;
        repeat (19) @(negedge clk);
    endtask

    task automatic release_btn();
        btn_load = 1'b0;
        repeat (22) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b0; btn_load = 1'b0; sw = 2'd0; sw_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            obs = {op_a, op_b, op_mode, result, result_cout, result_valid} ^ {7'd0, phase};
            checks++;
            if ({op_a, op_b, op_mode, result, result_cout, result_valid, phase} !== 11'd0)
                $display("FAIL reset_idle cycle %0d got outputs=%b phase=%0d exp all 0", i,
                         {op_a, op_b, op_mode, result, result_cout, result_valid}, phase);
            else passes++;
        end
    endtask

    task automatic test_add();
        sw = 2'd2; sw_mode = 1'b0;
        press_hold();
        checks++;
        if (op_a !== 2'd2 || phase !== 2'd1)
            $display("FAIL add_load_a got op_a=%0d phase=%0d exp 2/1", op_a, phase);
        else passes++;
        release_btn();
        sw = 2'd1; sw_mode = 1'b0;
        press_hold();
        checks++;
        if (op_b !== 2'd1 || op_mode !== 1'b0 || phase !== 2'd2 || result_valid !== 1'b0)
            $display("FAIL add_load_b got op_b=%0d mode=%0d phase=%0d valid=%0d exp 1/0/2/0",
                     op_b, op_mode, phase, result_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (result !== 2'd3 || result_cout !== 1'b0 || result_valid !== 1'b1 || phase !== 2'd3)
            $display("FAIL add_result got r=%0d c=%0d v=%0d phase=%0d exp 3/0/1/3",
                     result, result_cout, result_valid, phase);
        else passes++;
        release_btn();
    endtask

    task automatic test_subtract();
        press_hold();
        checks++;
        if (phase !== 2'd0 || result_valid !== 1'b0)
            $display("FAIL ack_after_add got phase=%0d valid=%0d exp 0/0", phase, result_valid);
        else passes++;
        release_btn();
        sw = 2'd3; sw_mode = 1'b0;
        press_hold();
        release_btn();
        sw = 2'd1; sw_mode = 1'b1;
        press_hold();
        @(negedge clk);
        checks++;
        if (result !== 2'd2 || result_cout !== 1'b1 || result_valid !== 1'b1 || phase !== 2'd3)
            $display("FAIL sub_result got r=%0d c=%0d v=%0d phase=%0d exp 2/1/1/3",
                     result, result_cout, result_valid, phase);
        else passes++;
        release_btn();
        press_hold();
        checks++;
        if (result_valid !== 1'b0 || phase !== 2'd0 || op_a !== 2'd3)
            $display("FAIL sub_ack got v=%0d phase=%0d op_a=%0d exp 0/0/3",
                     result_valid, phase, op_a);
        else passes++;
        release_btn();
    endtask

    task automatic test_bounce();
        bit moved = 1'b0;
        sw = 2'd2; sw_mode = 1'b0;
        for (int s = 0; s < 14; s++) begin
            btn_load = (s % 2 == 0);
            repeat (3) @(negedge clk);
        end
        checks++;
        if (phase !== 2'd0) $display("FAIL bounce_no_pulse got phase=%0d exp 0", phase);
        else passes++;
        btn_load = 1'b1;
        repeat (18) @(negedge clk);
        checks++;
        if (phase !== 2'd0) $display("FAIL bounce_early got phase=%0d exp 0", phase);
        else passes++;
        @(negedge clk);
        checks++;
        if (phase !== 2'd1 || op_a !== 2'd2)
            $display("FAIL bounce_pulse got phase=%0d op_a=%0d exp 1/2", phase, op_a);
        else passes++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (phase !== 2'd1) moved = 1'b1;
        end
        checks++;
        if (moved) $display("FAIL hold_single_pulse got phase moved=1 exp 0");
        else passes++;
        release_btn();
    endtask

    task automatic test_sw_change();
        sw = 2'd0; repeat (5) @(negedge clk);
        sw = 2'd3; sw_mode = 1'b1; repeat (5) @(negedge clk);
        sw = 2'd1; repeat (5) @(negedge clk);
        checks++;
        if (op_a !== 2'd2 || phase !== 2'd1)
            $display("FAIL sw_change got op_a=%0d phase=%0d exp 2/1", op_a, phase);
        else passes++;
    endtask

    task automatic test_reset_mid();
        sw = 2'd3; sw_mode = 1'b1;
        btn_load = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({op_a, op_b, op_mode, result, result_cout, result_valid, phase} !== 11'd0)
            $display("FAIL reset_mid got outputs=%b phase=%0d exp all 0",
                     {op_a, op_b, op_mode, result, result_cout, result_valid}, phase);
        else passes++;
        @(negedge clk);
        btn_load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sw = 2'd1; sw_mode = 1'b0;
        press_hold();
        checks++;
        if (op_a !== 2'd1 || op_b !== 2'd0 || phase !== 2'd1)
            $display("FAIL reset_recover got op_a=%0d op_b=%0d phase=%0d exp 1/0/1",
                     op_a, op_b, phase);
        else passes++;
        release_btn();
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_bounce();
        test_sw_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
